// File: rtl/lieat_axi_master_pkg.sv
// -----------------------------------------------------------------------------
// lieat_axi_master_pkg
//   Shared definitions for the lieat AXI4 initiator bridge:
//     - bus widths (address, data, strobe, ID, burst length, size)
//     - AXI burst type and response codes
//     - bridge FSM state encoding
//     - helpers for the optional alignment / 4KB-crossing request check
//       (used only when LIEAT_AXI_MASTER_ALIGN_CHECK_EN is defined)
// -----------------------------------------------------------------------------
package lieat_axi_master_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  localparam logic [ID_W-1:0] AXI_ID_DEFAULT = 4'd0;

  // AXI burst types
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI response codes; bit 1 set means SLVERR/DECERR
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // IDLE must stay at encoding 0: the state flop resets to all-zeros.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // True when addr has any bit set below the 2^size boundary.
  function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr,
                                           input logic [SIZE_W-1:0] size);
    logic [ADDR_W-1:0] mask;
    mask = (ADDR_W'(1) << size) - ADDR_W'(1);
    return |(addr & mask);
  endfunction

  // True when an INCR burst of (len+1) beats of 2^size bytes starting at addr
  // runs past the end of its 4KB page. 17 bits hold the worst case
  // (4095 + 256 * 128).
  function automatic logic crosses_4k(input logic [ADDR_W-1:0] addr,
                                      input logic [SIZE_W-1:0] size,
                                      input logic [LEN_W-1:0]  len);
    logic [16:0] span;
    logic [16:0] end_off;
    span    = (17'(len) + 17'd1) << size;
    end_off = 17'(addr[11:0]) + span;
    return end_off > 17'd4096;
  endfunction

endpackage

// File: rtl/lieat_axi_master_dff.sv
// -----------------------------------------------------------------------------
// lieat_axi_master_dff
//   General W-bit D flip-flop with asynchronous active-low reset to zero.
//   Ports:
//     clock  in  1  rising-edge clock
//     rst_n  in  1  asynchronous active-low reset (q -> 0)
//     d      in  W  next value
//     q      out W  registered value
// -----------------------------------------------------------------------------
module lieat_axi_master_dff #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/lieat_axi_master.sv
// -----------------------------------------------------------------------------
// lieat_axi_master
//   AXI4 initiator bridge. Converts the core's single-outstanding
//   request/response port into AXI4 transactions on io_master_*.
//   Reads may be INCR bursts (len+1 beats); writes are always single-beat.
//   Exactly one transaction is in flight at a time.
//
//   Optional build macro: LIEAT_AXI_MASTER_ALIGN_CHECK_EN
//     When defined, misaligned requests and read bursts crossing a 4KB page
//     are not issued; a single error response (err=1, last=1, rdata=0) is
//     returned instead.
//
//   Ports:
//     clock, reset              clock and asynchronous active-low reset
//     req_*                     request in (valid/ready, write, addr, size,
//                               len, wdata, wstrb)
//     rsp_*                     response out (valid/ready, rdata, last, err)
//     io_master_aw*/w*/b*       AXI4 write address/data/response channels
//     io_master_ar*/r*          AXI4 read address/data channels
// -----------------------------------------------------------------------------
module lieat_axi_master
  import lieat_axi_master_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = AXI_ID_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SIZE_W-1:0] req_size,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              rsp_err,

  output logic              io_master_awvalid,
  input  logic              io_master_awready,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [ID_W-1:0]   io_master_awid,
  output logic [LEN_W-1:0]  io_master_awlen,
  output logic [SIZE_W-1:0] io_master_awsize,
  output logic [1:0]        io_master_awburst,

  output logic              io_master_wvalid,
  input  logic              io_master_wready,
  output logic [DATA_W-1:0] io_master_wdata,
  output logic [STRB_W-1:0] io_master_wstrb,
  output logic              io_master_wlast,

  input  logic              io_master_bvalid,
  output logic              io_master_bready,
  input  logic [1:0]        io_master_bresp,
  input  logic [ID_W-1:0]   io_master_bid,

  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [ID_W-1:0]   io_master_arid,
  output logic [LEN_W-1:0]  io_master_arlen,
  output logic [SIZE_W-1:0] io_master_arsize,
  output logic [1:0]        io_master_arburst,

  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [1:0]        io_master_rresp,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic              io_master_rlast,
  input  logic [ID_W-1:0]   io_master_rid
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e            state_d;
  state_e            state_q;
  logic [2:0]        state_bits_q;
  logic [ADDR_W-1:0] addr_d,    addr_q;
  logic [SIZE_W-1:0] size_d,    size_q;
  logic [LEN_W-1:0]  len_d,     len_q;
  logic [DATA_W-1:0] wdata_d,   wdata_q;
  logic [STRB_W-1:0] wstrb_d,   wstrb_q;
  logic [LEN_W-1:0]  beat_d,    beat_q;
  logic              aw_done_d, aw_done_q;
  logic              w_done_d,  w_done_q;

  assign state_q = state_e'(state_bits_q);

  lieat_axi_master_dff #(.W(3)) u_state_q (
    .clock(clock), .rst_n(reset), .d(state_d), .q(state_bits_q));
  lieat_axi_master_dff #(.W(ADDR_W)) u_addr_q (
    .clock(clock), .rst_n(reset), .d(addr_d), .q(addr_q));
  lieat_axi_master_dff #(.W(SIZE_W)) u_size_q (
    .clock(clock), .rst_n(reset), .d(size_d), .q(size_q));
  lieat_axi_master_dff #(.W(LEN_W)) u_len_q (
    .clock(clock), .rst_n(reset), .d(len_d), .q(len_q));
  lieat_axi_master_dff #(.W(DATA_W)) u_wdata_q (
    .clock(clock), .rst_n(reset), .d(wdata_d), .q(wdata_q));
  lieat_axi_master_dff #(.W(STRB_W)) u_wstrb_q (
    .clock(clock), .rst_n(reset), .d(wstrb_d), .q(wstrb_q));
  lieat_axi_master_dff #(.W(LEN_W)) u_beat_q (
    .clock(clock), .rst_n(reset), .d(beat_d), .q(beat_q));
  lieat_axi_master_dff #(.W(1)) u_aw_done_q (
    .clock(clock), .rst_n(reset), .d(aw_done_d), .q(aw_done_q));
  lieat_axi_master_dff #(.W(1)) u_w_done_q (
    .clock(clock), .rst_n(reset), .d(w_done_d), .q(w_done_q));

  // ---------------------------------------------------------------------------
  // Request screening
  // ---------------------------------------------------------------------------
  logic req_bad;
`ifdef LIEAT_AXI_MASTER_ALIGN_CHECK_EN
  // Page crossing only matters for reads; writes are always one beat and an
  // aligned single beat cannot straddle a page.
  assign req_bad = addr_misaligned(req_addr, req_size) |
                   (!req_write && crosses_4k(req_addr, req_size, req_len));
`else
  assign req_bad = 1'b0;
`endif

  // The beat currently on R is the one the request asked to be last.
  logic beat_is_last;
  assign beat_is_last = (beat_q == len_q);

  // ---------------------------------------------------------------------------
  // Constant / latched channel payloads (stable while the state is held)
  // ---------------------------------------------------------------------------
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = BURST_INCR;

  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = '0;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = BURST_INCR;

  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;

  // Only resp[1] distinguishes error from OK; EXOKAY is treated as OKAY.
  logic unused_resp_lsb;
  assign unused_resp_lsb = io_master_rresp[0] ^ io_master_bresp[0];

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    beat_d    = beat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    req_ready         = 1'b0;
    rsp_valid         = 1'b0;
    rsp_rdata         = '0;
    rsp_last          = 1'b0;
    rsp_err           = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          len_d     = req_len;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          beat_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_bad) begin
            state_d = ST_ERR;
          end else if (req_write) begin
            state_d = ST_AW_W;
          end else begin
            state_d = ST_AR;
          end
        end
      end

      ST_AR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) begin
          beat_d  = '0;
          state_d = ST_R;
        end
      end

      ST_R: begin
        // Consumer backpressure goes straight onto R; nothing is buffered.
        io_master_rready = rsp_ready;
        rsp_valid        = io_master_rvalid;
        rsp_rdata        = io_master_rdata;
        rsp_last         = beat_is_last;
        rsp_err          = io_master_rresp[1] |
                           (io_master_rid != AXI_ID) |
                           (io_master_rlast != beat_is_last);
        if (io_master_rvalid && rsp_ready) begin
          beat_d = beat_q + LEN_W'(1);
          // Leave on whichever end marker comes first; a disagreement is
          // already flagged through rsp_err on this beat.
          if (io_master_rlast || beat_is_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_AW_W: begin
        io_master_awvalid = !aw_done_q;
        io_master_wvalid  = !w_done_q;
        aw_done_d = aw_done_q | io_master_awready;
        w_done_d  = w_done_q  | io_master_wready;
        if (aw_done_d && w_done_d) begin
          state_d = ST_B;
        end
      end

      ST_B: begin
        io_master_bready = rsp_ready;
        rsp_valid        = io_master_bvalid;
        rsp_last         = 1'b1;
        rsp_err          = io_master_bresp[1] | (io_master_bid != AXI_ID);
        if (io_master_bvalid && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERR: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        rsp_err   = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lieat_axi_master.sv
// -----------------------------------------------------------------------------
// tb_lieat_axi_master
//   Bench for lieat_axi_master: the bench acts as core and as AXI responder.
//   Directed vectors in a table plus randomized vectors whose expectations are
//   derived from the transaction rules, plus hand-written reset and
//   (when LIEAT_AXI_MASTER_ALIGN_CHECK_EN is defined) alignment sequences.
// -----------------------------------------------------------------------------
module tb_lieat_axi_master;

  localparam logic [3:0] AXI_ID = 4'd0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [7:0]  req_len = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_last, rsp_err;
  logic [63:0] rsp_rdata;
  logic        awvalid, awready = 1'b0;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready = 1'b0, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = '0;
  logic [3:0]  bid = '0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready, rlast = 1'b0;
  logic [1:0]  rresp = '0;
  logic [63:0] rdata = '0;
  logic [3:0]  rid = '0;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  always #5 clock = ~clock;

  lieat_axi_master #(.AXI_ID(AXI_ID)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready),
    .io_master_awaddr(awaddr), .io_master_awid(awid), .io_master_awlen(awlen),
    .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready),
    .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready),
    .io_master_bresp(bresp), .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready),
    .io_master_araddr(araddr), .io_master_arid(arid), .io_master_arlen(arlen),
    .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready),
    .io_master_rresp(rresp), .io_master_rdata(rdata),
    .io_master_rlast(rlast), .io_master_rid(rid)
  );

  // One transaction record: stimulus plus expected outcome.
  // beats      : R beats the responder offers (rlast on the final one
  //              unless no_last)
  // dly / wdly : cycles before arready|awready / wready
  // stall_beat : R beat on which rsp_ready is held low for 2 cycles (-1 none)
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [63:0] data;
    logic [7:0]  wstrb;
    int          beats;
    bit          no_last;
    logic [1:0]  resp;
    logic [3:0]  id;
    int          dly;
    int          wdly;
    int          stall_beat;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [2:0] size,
                              logic [7:0] len, logic [63:0] data,
                              logic [7:0] wstrb, int beats, bit no_last,
                              logic [1:0] resp, logic [3:0] id, int dly,
                              int wdly, int stall_beat, int exp_beats,
                              bit exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.len = len; v.data = data;
    v.wstrb = wstrb; v.beats = beats; v.no_last = no_last; v.resp = resp;
    v.id = id; v.dly = dly; v.wdly = wdly; v.stall_beat = stall_beat;
    v.exp_beats = exp_beats; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference outcome of a whole transaction from the bridge's rules:
  // a read ends at the first end marker (rlast or beat len); any error
  // response, wrong ID, or disagreement between the two markers is an error.
  function automatic vec_t model(vec_t v);
    vec_t r;
    int   want;
    r = v;
    if (v.wr) begin
      r.exp_beats = 1;
      r.exp_err   = v.resp[1] || (v.id != AXI_ID);
    end else begin
      want        = int'(v.len) + 1;
      r.exp_beats = v.no_last ? want : ((v.beats < want) ? v.beats : want);
      r.exp_err   = v.resp[1] || (v.id != AXI_ID) || v.no_last ||
                    (v.beats != want);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (txn %0d, t=%0t)", name, act, exp,
               txn, $time);
    end
  endtask

  // Present the request for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input vec_t v);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_size = v.size;
    req_len = v.len; req_wdata = v.data; req_wstrb = v.wstrb;
    #1;
    chk("req_ready_idle", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = {$urandom, $urandom};
  endtask

  task automatic do_read(input vec_t v, output int nb, output bit anyerr);
    int  k, stall, cyc;
    bit  done, present, exp_last, exp_err;
    nb = 0; anyerr = 0;
    for (int c = 0; c <= v.dly; c++) begin
      arready = (c == v.dly);
      #1;
      chk("arvalid", arvalid, 1);
      chk("rsp_valid_ar", rsp_valid, 0);
      if (c == 0) begin
        chk("araddr", araddr, v.addr);
        chk("arlen", arlen, v.len);
        chk("arsize", arsize, v.size);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, AXI_ID);
      end
      @(negedge clock);
    end
    arready = 1'b0;
    k = 0; stall = 0; cyc = 0; done = 0;
    while (!done) begin
      if (cyc >= 300) begin
        chk("r_timeout", 0, 1);
        break;
      end
      present = (k < v.beats);
      if (present && k == v.stall_beat && stall < 2) begin
        rvalid = 1'b1; rsp_ready = 1'b0; stall++;
      end else begin
        rvalid    = present && ($urandom_range(0, 3) != 0);
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      rdata = v.data + 64'(k);
      rlast = present && (k == v.beats - 1) && !v.no_last;
      rresp = v.resp; rid = v.id;
      #1;
      chk("rready", rready, rsp_ready);
      chk("rsp_valid_r", rsp_valid, rvalid);
      if (rvalid && rsp_ready) begin
        exp_last = (k == int'(v.len));
        exp_err  = v.resp[1] || (v.id != AXI_ID) || (rlast != exp_last);
        chk("r_data", rsp_rdata, v.data + 64'(k));
        chk("r_last", rsp_last, exp_last);
        chk("r_err", rsp_err, exp_err);
        nb++;
        anyerr |= rsp_err;
        if (rlast || exp_last) done = 1;
        k++;
      end
      @(negedge clock);
      cyc++;
    end
    // A stray beat after the end must be ignored.
    rvalid = 1'b1; rsp_ready = 1'b1; rlast = 1'b0;
    #1;
    chk("stray_rready", rready, 0);
    chk("stray_rsp_valid", rsp_valid, 0);
    chk("idle_after_read", req_ready, 1);
    @(negedge clock);
    rvalid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic do_write(input vec_t v, output int nb, output bit anyerr);
    bit awd, wd, done;
    int cyc;
    nb = 0; anyerr = 0; awd = 0; wd = 0; cyc = 0;
    while (!(awd && wd)) begin
      if (cyc >= 50) begin
        chk("aw_w_timeout", 0, 1);
        break;
      end
      awready = !awd && (cyc >= v.dly);
      wready  = !wd && (cyc >= v.wdly);
      #1;
      chk("awvalid", awvalid, !awd);
      chk("wvalid", wvalid, !wd);
      chk("rsp_valid_aw", rsp_valid, 0);
      if (!awd && cyc == 0) begin
        chk("awaddr", awaddr, v.addr);
        chk("awlen", awlen, 0);
        chk("awsize", awsize, v.size);
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, AXI_ID);
      end
      if (!wd && cyc == 0) begin
        chk("wdata", wdata, v.data);
        chk("wstrb", wstrb, v.wstrb);
        chk("wlast", wlast, 1);
      end
      awd |= awready;
      wd  |= wready;
      @(negedge clock);
      cyc++;
    end
    awready = 1'b0; wready = 1'b0;
    done = 0; cyc = 0;
    while (!done) begin
      if (cyc >= 50) begin
        chk("b_timeout", 0, 1);
        break;
      end
      bvalid    = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      bresp = v.resp; bid = v.id;
      #1;
      chk("bready", bready, rsp_ready);
      chk("rsp_valid_b", rsp_valid, bvalid);
      chk("awvalid_b", awvalid, 0);
      chk("wvalid_b", wvalid, 0);
      if (bvalid && rsp_ready) begin
        chk("b_last", rsp_last, 1);
        chk("b_rdata", rsp_rdata, 0);
        chk("b_err", rsp_err, v.resp[1] || (v.id != AXI_ID));
        nb++;
        anyerr |= rsp_err;
        done = 1;
      end
      @(negedge clock);
      cyc++;
    end
    bvalid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("idle_after_write", req_ready, 1);
    @(negedge clock);
  endtask

  task automatic run_vec(input vec_t v);
    int nb;
    bit anyerr;
    txn++;
    issue(v);
    if (v.wr) do_write(v, nb, anyerr);
    else      do_read(v, nb, anyerr);
    chk("txn_beats", nb, v.exp_beats);
    chk("txn_err", anyerr, v.exp_err);
    $display("txn %0d %s addr=%h size=%0d len=%0d beats=%0d err=%0b", txn,
             v.wr ? "WR" : "RD", v.addr, v.size, v.len, nb, anyerr);
  endtask

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    logic [31:0] r;

    tbl[0] = mk(0, 32'h8000_0000, 3, 0, 64'hDEAD_BEEF_0123_4567, 8'h00,
                1, 0, 2'b00, 4'h0, 0, 0, -1, 1, 0);
    tbl[1] = mk(0, 32'h8000_1000, 3, 3, 64'h0000_0000_0000_1000, 8'h00,
                4, 0, 2'b00, 4'h0, 0, 0, 2, 4, 0);
    tbl[2] = mk(1, 32'h8000_2000, 3, 0, 64'h1122_3344_5566_7788, 8'hF0,
                1, 0, 2'b00, 4'h0, 1, 0, -1, 1, 0);
    tbl[3] = mk(1, 32'h8000_2008, 3, 0, 64'hCAFE_F00D_0000_0001, 8'hFF,
                1, 0, 2'b10, 4'h0, 0, 0, -1, 1, 1);
    tbl[4] = mk(0, 32'h8000_3000, 3, 1, 64'h0000_0000_AAAA_0000, 8'h00,
                2, 0, 2'b00, 4'h3, 0, 0, -1, 2, 1);
    tbl[5] = mk(0, 32'h8000_4000, 3, 3, 64'h0000_0000_BBBB_0000, 8'h00,
                2, 0, 2'b00, 4'h0, 1, 0, -1, 2, 1);
    tbl[6] = mk(0, 32'h8000_5000, 2, 2, 64'h0000_0000_CCCC_0000, 8'h00,
                3, 1, 2'b00, 4'h0, 0, 0, -1, 3, 1);
    tbl[7] = mk(0, 32'h8000_6000, 3, 0, 64'h0000_0000_DDDD_0000, 8'h00,
                1, 0, 2'b11, 4'h0, 0, 0, -1, 1, 1);
    tbl[8] = mk(1, 32'h8000_7004, 2, 8'h5A, 64'h0123_4567_89AB_CDEF, 8'h0F,
                1, 0, 2'b00, 4'h0, 0, 2, -1, 1, 0);
    tbl[9] = mk(0, 32'h8000_8004, 2, 1, 64'h0000_0000_EEEE_0000, 8'h00,
                2, 0, 2'b01, 4'h0, 2, 0, -1, 2, 0);

    // Reset state
    #2;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Randomized vectors; expectations from the reference model
    for (int i = 0; i < 40; i++) begin
      int mode;
      v.wr    = ($urandom_range(0, 2) == 0);
      v.size  = 3'($urandom_range(0, 3));
      v.len   = v.wr ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      r       = $urandom;
      v.addr  = (r & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << v.size);
      v.data  = {$urandom, $urandom};
      v.wstrb = 8'($urandom_range(0, 255));
      v.beats = int'(v.len) + 1;
      v.no_last = 0;
      mode = $urandom_range(0, 5);
      if (!v.wr && mode == 0 && v.len > 0) v.beats = $urandom_range(1, int'(v.len));
      if (!v.wr && mode == 1) v.no_last = 1;
      v.resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                           : 2'($urandom_range(0, 1));
      v.id   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : AXI_ID;
      v.dly  = $urandom_range(0, 2);
      v.wdly = $urandom_range(0, 2);
      v.stall_beat = ($urandom_range(0, 1) == 0) ? -1
                     : int'($urandom_range(0, int'(v.len)));
      v = model(v);
      run_vec(v);
    end

    // Reset in the middle of a len=7 burst
    txn++;
    v = mk(0, 32'h8000_9000, 3, 7, 64'h0000_0000_5555_0000, 8'h00,
           8, 0, 2'b00, 4'h0, 0, 0, -1, 8, 0);
    issue(v);
    arready = 1'b1;
    #1;
    chk("mid_arvalid", arvalid, 1);
    @(negedge clock);
    arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rvalid = 1'b1; rsp_ready = (k < 2); rdata = v.data + 64'(k); rlast = 1'b0;
      #1;
      chk("mid_rsp_valid", rsp_valid, 1);
      if (k < 2) chk("mid_data", rsp_rdata, v.data + 64'(k));
      if (k < 2) @(negedge clock);
    end
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_rready", rready, 0);
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_awvalid", awvalid, 0);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_bready", bready, 0);
    @(negedge clock);
    rvalid = 1'b0; rsp_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_release_req_ready", req_ready, 1);
    $display("txn %0d RD reset mid-burst addr=%h", txn, v.addr);
    @(negedge clock);
    run_vec(mk(0, 32'h8000_A000, 3, 1, 64'h0000_0000_7777_0000, 8'h00,
               2, 0, 2'b00, 4'h0, 0, 0, -1, 2, 0));

`ifdef LIEAT_AXI_MASTER_ALIGN_CHECK_EN
    // Misaligned read is answered locally, never reaching AR.
    txn++;
    v = mk(0, 32'h8000_0004, 3, 0, 64'h0, 8'h00,
           1, 0, 2'b00, 4'h0, 0, 0, -1, 1, 1);
    issue(v);
    for (int c = 0; c < 3; c++) begin
      rsp_ready = (c == 2);
      #1;
      chk("al_arvalid", arvalid, 0);
      chk("al_rsp_valid", rsp_valid, 1);
      chk("al_err", rsp_err, 1);
      chk("al_last", rsp_last, 1);
      chk("al_rdata", rsp_rdata, 0);
      @(negedge clock);
    end
    rsp_ready = 1'b0;
    #1;
    chk("al_arvalid_after", arvalid, 0);
    chk("al_idle", req_ready, 1);
    $display("txn %0d RD misaligned addr=%h rejected", txn, v.addr);
    @(negedge clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lieat_axi_master.md
Name: lieat_axi_master

Overview:
- AXI4 initiator bridge: converts the core's single-outstanding request/response port (IFU/LSU arbiter output) into AXI4 transactions on the io_master_* bus.
- Drives the bus that the SoC AXI slave/SRAM responder terminates.
- Read supports INCR bursts (cache-line refill). Write is single-beat.
- One transaction in flight at a time.

Parameters:
- AXI_ID, 4'd0, constant value driven on arid/awid and expected back on rid/bid.
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  bridge idle, request accepted on valid&&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_size  in  3  AXI size encoding (0..3)
- req_len  in  8  read beats minus 1; ignored for writes
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  write strobes
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  consumer accepts beat
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_last  out  1  final beat of transaction
- rsp_err  out  1  SLVERR/DECERR, ID mismatch or beat-count mismatch
- io_master_aw{valid,ready,addr,id,len,size,burst}  out/in/out/out/out/out/out  1/1/ADDR_W/4/8/3/2
- io_master_w{valid,ready,data,strb,last}  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1
- io_master_b{valid,ready,resp,id}  in/out/in/in  1/1/2/4
- io_master_ar{valid,ready,addr,id,len,size,burst}  out/in/out/out/out/out/out  1/1/ADDR_W/4/8/3/2
- io_master_r{valid,ready,resp,data,last,id}  in/out/in/in/in/in  1/1/2/DATA_W/1/4

Behaviour:
- Reset (reset=0): state=IDLE, all AXI valids/readies 0, rsp_valid 0, latched request regs 0. Takes effect immediately, including mid-transaction; the SoC shares this reset, so an abandoned handshake is acceptable.
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE:
  - req_ready=1; in every other state req_ready=0.
  - On accept, latch addr/size/len/wdata/wstrb.
  - Go to AR (read) or AW_W (write).
- AR:
  - arvalid=1 (registered; first asserted the cycle after accept).
  - araddr/arsize/arlen from latch; arburst=2'b01 (INCR); arid=AXI_ID.
  - Payload is stable while arvalid=1.
  - On arready, go to R and clear the beat counter.
- R:
  - rready = rsp_ready (combinational).
  - rsp_valid = rvalid; rsp_rdata = rdata.
  - rsp_last = (beat counter == latched len).
  - rsp_err = rresp[1] | (rid != AXI_ID) | (rlast != rsp_last).
  - Counter increments on each rvalid&&rready.
  - Exit to IDLE on a handshaked beat with rlast=1 or counter==len, whichever comes first. Error is flagged on that beat; any further R beats arriving in IDLE are ignored with rready=0.
- AW_W:
  - awvalid and wvalid both asserted from the cycle after accept.
  - awlen=0, awburst=INCR, wlast=1.
  - Each valid drops independently after its own handshake (aw_done/w_done flags). Same-cycle handshake of both is legal.
  - When both are done, go to B.
- B:
  - bready = rsp_ready; rsp_valid = bvalid; rsp_last=1; rsp_rdata=0.
  - rsp_err = bresp[1] | (bid != AXI_ID).
  - On handshake, go to IDLE.
- Latency: with a zero-wait responder, a read accepted at cycle 0 gives ar handshake at cycle 1 and earliest rsp at cycle 2. A write gives aw/w at cycle 1 and earliest rsp at cycle 2.
- Back-to-back: a new request can be accepted the cycle after the final response beat.
- Backpressure: rsp_ready=0 stalls the AXI R/B channels directly; no internal buffering.

Optional Feature:
- Macro: LIEAT_AXI_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A request with addr not aligned to 2^size, or a read burst crossing a 4KB boundary, is not issued to AXI.
  - FSM goes to an ERR state that presents rsp_valid=1, rsp_err=1, rsp_last=1, rsp_rdata=0 until rsp_ready, then returns to IDLE.
- Undefined: no check; requests are issued as given.

Decomposition:
- Shared package/defines: AXI burst codes (FIXED/INCR/WRAP), resp codes (OKAY/EXOKAY/SLVERR/DECERR), address/data/ID widths, FSM state encoding.
- State, latch and done-flag registers use the shared general DFF cell with async active-low reset.
- No sub-module needed; single module.

Test Plan:
- Read, len=0, addr 0x8000_0000, size 3; slave returns 0xDEAD_BEEF_0123_4567 OKAY with rlast -> one rsp beat with that data, last=1, err=0; arvalid seen at cycle 1.
- Read, len=3; slave returns beats 0..3, then rsp_ready held low for 2 cycles on beat 2 -> rready follows rsp_ready, 4 beats in order, last only on beat 3, no data lost.
- Write 0x1122_3344_5566_7788 with wstrb 0xF0; slave asserts wready 1 cycle before awready -> wvalid drops first, awvalid held; single B response -> rsp last=1, err=0.
- Write with bresp=2'b10 -> rsp_err=1. Read with rid≠AXI_ID -> rsp_err=1. Read with early rlast at beat 1 of len=3 -> err=1 on beat 1, then return to IDLE.
- Reset asserted during the R state of a len=7 burst -> all valids and rsp_valid drop immediately. After release, req_ready=1 and the next read completes normally.
- With ALIGN_CHECK_EN, read addr 0x8000_0004 size 3 -> no arvalid ever; one rsp with err=1, last=1.
